// File: rtl/board_pkg.sv
// board_pkg: board-level constants shared by the fabric blocks around cpu_sys.
`default_nettype none
package board_pkg;
  localparam int FCLK_HZ     = 50_000_000;
  localparam int N_BTNS      = 2;
  localparam int DEBOUNCE_MS = 10;
endpackage
`default_nettype wire

// File: rtl/btn_debounce_ch.sv
// btn_debounce_ch: one button channel - synchroniser, stability counter, level, edge pulses.
`default_nettype none
module btn_debounce_ch #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rstn,
  input  logic btn_raw_i,
  output logic btn_db_o,
  output logic btn_rise_o,
  output logic btn_fall_o,
  output logic evt_d_o
);
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DEBOUNCE_CYCLES - 1);

  (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] sync_q;
  logic             btn_s;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             db_q, db_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;

  assign btn_s = sync_q[SYNC_STAGES-1];

  always_comb begin
    cnt_d  = '0;
    db_d   = db_q;
    rise_d = 1'b0;
    fall_d = 1'b0;
    if (btn_s != db_q) begin
      if (cnt_q == LAST_CNT) begin
        // Level held long enough: accept it and emit the matching edge pulse.
        db_d   = btn_s;
        rise_d = btn_s;
        fall_d = ~btn_s;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      sync_q <= '0;
      cnt_q  <= '0;
      db_q   <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], btn_raw_i};
      cnt_q  <= cnt_d;
      db_q   <= db_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign btn_db_o   = db_q;
  assign btn_rise_o = rise_q;
  assign btn_fall_o = fall_q;
  assign evt_d_o    = rise_d | fall_d;
endmodule
`default_nettype wire

// File: rtl/btn_debounce.sv
// btn_debounce: debounces the push-button pads feeding btns_2bits_tri_i and flags any edge on btn_evt.
`default_nettype none
module btn_debounce
  import board_pkg::*;
#(
  parameter int N_BTNS          = board_pkg::N_BTNS,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = FCLK_HZ / 1000 * DEBOUNCE_MS
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [N_BTNS-1:0] btn_raw,
  output logic [N_BTNS-1:0] btn_db,
  output logic [N_BTNS-1:0] btn_rise,
  output logic [N_BTNS-1:0] btn_fall,
  output logic              btn_evt
);
  logic [N_BTNS-1:0] evt_d;
  logic              evt_q;

  for (genvar i = 0; i < N_BTNS; i++) begin : g_ch
    btn_debounce_ch #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_ch (
      .clk        (clk),
      .rstn       (rstn),
      .btn_raw_i  (btn_raw[i]),
      .btn_db_o   (btn_db[i]),
      .btn_rise_o (btn_rise[i]),
      .btn_fall_o (btn_fall[i]),
      .evt_d_o    (evt_d[i])
    );
  end

  // Built from the channels' next-pulse terms so it lines up with the pulses.
  always_ff @(posedge clk) begin
    if (!rstn) evt_q <= 1'b0;
    else       evt_q <= |evt_d;
  end

  assign btn_evt = evt_q;
endmodule
`default_nettype wire

// File: tb/tb_btn_debounce.sv
// tb_btn_debounce: directed scenarios plus a random run against a behavioural model.
`default_nettype none
module tb_btn_debounce;
  localparam int NB = 2;
  localparam int SS = 2;
  localparam int DC = 4;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic [NB-1:0] btn_raw = '0;
  logic [NB-1:0] btn_db, btn_rise, btn_fall;
  logic          btn_evt;
  logic [6:0]    obs;

  int n_vec = 0;
  int n_err = 0;

  logic [NB-1:0] m_sync [SS];
  int            m_cnt  [NB];
  logic [NB-1:0] m_db, m_rise, m_fall;
  logic          m_evt;

  btn_debounce #(
    .N_BTNS          (NB),
    .SYNC_STAGES     (SS),
    .DEBOUNCE_CYCLES (DC)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .btn_raw  (btn_raw),
    .btn_db   (btn_db),
    .btn_rise (btn_rise),
    .btn_fall (btn_fall),
    .btn_evt  (btn_evt)
  );

  always #5 clk = ~clk;
  assign obs = {btn_db, btn_rise, btn_fall, btn_evt};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model of one clock edge, using the inputs about to be sampled.
  task automatic model_edge();
    if (!rstn) begin
      for (int j = 0; j < SS; j++) m_sync[j] = '0;
      for (int i = 0; i < NB; i++) m_cnt[i] = 0;
      m_db = '0; m_rise = '0; m_fall = '0; m_evt = 1'b0;
    end else begin
      for (int i = 0; i < NB; i++) begin
        m_rise[i] = 1'b0;
        m_fall[i] = 1'b0;
        if (m_sync[SS-1][i] == m_db[i]) m_cnt[i] = 0;
        else if (m_cnt[i] < DC - 1) m_cnt[i]++;
        else begin
          m_cnt[i] = 0;
          m_db[i]  = m_sync[SS-1][i];
          if (m_db[i]) m_rise[i] = 1'b1;
          else         m_fall[i] = 1'b1;
        end
      end
      m_evt = |(m_rise | m_fall);
      for (int j = SS - 1; j > 0; j--) m_sync[j] = m_sync[j-1];
      m_sync[0] = btn_raw;
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [17:0] bounce;

    // Reset with both buttons held, then a normal debounced press after release
    rstn = 1'b0; btn_raw = 2'b11;
    for (int c = 0; c < 3; c++) begin step(); chk("rst_outs", obs, 7'd0); end
    rstn = 1'b1;
    for (int c = 0; c < 5; c++) begin step(); chk("rst_rel_wait", obs, 7'd0); end
    step(); chk("rst_rel_rise", obs, {2'b11, 2'b11, 2'b00, 1'b1});
    step(); chk("rst_rel_after", obs, {2'b11, 2'b00, 2'b00, 1'b0});

    // Release both channels on the same edge
    btn_raw = 2'b00;
    for (int c = 0; c < 5; c++) begin step(); chk("rel_wait", obs, {2'b11, 2'b00, 2'b00, 1'b0}); end
    step(); chk("rel_fall", obs, {2'b00, 2'b00, 2'b11, 1'b1});
    step(); chk("rel_after", obs, 7'd0);

    // Clean press on ch0
    btn_raw = 2'b01;
    for (int c = 0; c < 5; c++) begin step(); chk("press_wait", obs, 7'd0); end
    step(); chk("press_rise", obs, {2'b01, 2'b01, 2'b00, 1'b1});
    step(); chk("press_after", obs, {2'b01, 2'b00, 2'b00, 1'b0});

    // Bounce on ch1: 1010, ten 0s, three 1s (one short of the threshold), then 0s
    bounce = 18'b1010_0000000000_1110;
    for (int c = 17; c >= 0; c--) begin
      btn_raw = {bounce[c], 1'b1};
      step(); chk("bounce_hold", obs, {2'b01, 2'b00, 2'b00, 1'b0});
    end
    btn_raw = 2'b01;
    for (int c = 0; c < 8; c++) begin step(); chk("bounce_tail", obs, {2'b01, 2'b00, 2'b00, 1'b0}); end

    // Return ch0 to 0, then reset in the middle of a new press
    btn_raw = 2'b00;
    for (int c = 0; c < 5; c++) step();
    step(); chk("ch0_fall", obs, {2'b00, 2'b00, 2'b01, 1'b1});
    step();
    btn_raw = 2'b01;
    for (int c = 0; c < 4; c++) begin step(); chk("midcnt_wait", obs, 7'd0); end
    rstn = 1'b0;
    for (int c = 0; c < 2; c++) begin step(); chk("midcnt_rst", obs, 7'd0); end
    rstn = 1'b1;
    for (int c = 0; c < 5; c++) begin step(); chk("midcnt_redo_wait", obs, 7'd0); end
    step(); chk("midcnt_redo_rise", obs, {2'b01, 2'b01, 2'b00, 1'b1});
    step(); chk("midcnt_redo_after", obs, {2'b01, 2'b00, 2'b00, 1'b0});

    // Random raw activity with occasional resets, cycle-exact against the model
    rstn = 1'b0; step();
    rstn = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < NB; i++)
        if ($urandom_range(0, 4) == 0) btn_raw[i] = ~btn_raw[i];
      rstn = ($urandom_range(0, 499) != 0);
      step();
      chk("rnd", obs, {m_db, m_rise, m_fall, m_evt});
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
`default_nettype wire
